core_bus_master: RTL and testbench
==================================

# core_bus_master

Host-side initiator for the core's shared memory port: it drives `address`, the bidirectional `data` bus, `wren` and `cpen` so that a controller can load programs and data into core memory and read them back. It accepts burst requests over a valid/ready interface, streams write words in, returns read words out, and owns bus turnaround so that `data` is never driven by both ends. It sits between the system loader or debug logic and the core's external memory port.

## Interface
- `DATA_WIDTH`, 16, width of `data`, write words and read words
- `ADDRESS_WIDTH`, 16, width of `address` and `req_addr`
- `LEN_WIDTH`, 8, width of `req_len`; a burst is `req_len`+1 words
- `READ_LATENCY`, 1, cycles from the first address cycle to the sample edge (≥1)

- `clk` input 1: the single clock; all logic is on its rising edge
- `rst_n` input 1: synchronous, active-low reset
- `req_valid` input 1: a burst request is present
- `req_ready` output 1: the block accepts a request; high only in IDLE
- `req_write` input 1: 1 selects a write burst, 0 selects a read burst
- `req_addr` input ADDRESS_WIDTH: start address of the burst
- `req_len` input LEN_WIDTH: word count minus 1
- `wdata_valid` input 1: a write word is present
- `wdata_ready` output 1: the block accepts a write word; high only in WR
- `wdata` input DATA_WIDTH: the write word
- `rsp_valid` output 1: one-cycle pulse marking a valid read word; there is no backpressure
- `rsp_rdata` output DATA_WIDTH: the read word; held until the next `rsp_valid`
- `rsp_last` output 1: qualifies `rsp_valid` on the final word of a burst
- `address` output ADDRESS_WIDTH: core memory address
- `data` inout DATA_WIDTH: shared bus; driven only while `wren`&`cpen`, otherwise high-Z
- `wren` output 1: core write enable
- `cpen` output 1: core port enable
- `busy` output 1: the state is not IDLE

## Operation
- **States:** IDLE, WR, RD, TURN.
- **IDLE**
  - `req_ready`=1.
  - A handshake (`req_valid`&`req_ready`) captures the address into `addr_q` and `req_len` into `cnt_q`.
  - Next state is WR if `req_write`=1, otherwise RD.
- **WR**
  - `wdata_ready`=1.
  - Each accepted word registers `address`=`addr_q`, the `data` driver value =`wdata`, and `wren`=`cpen`=1 for exactly the next cycle.
  - After each accepted word, `addr_q`+1 and `cnt_q`−1.
  - A cycle with no accepted word registers `wren`=`cpen`=0 for the next cycle, and the bus goes high-Z.
  - Accepting the word with `cnt_q`=0 moves the state to TURN.
- **RD**
  - `wren`=0, `cpen`=1, `data` released.
  - `address`=`addr_q` is held for READ_LATENCY+1 cycles.
  - At the last of those edges, `data` is sampled into `rsp_rdata`; `rsp_valid`=1 the following cycle, with `rsp_last`=1 if `cnt_q`=0.
  - Then `addr_q`+1 and `cnt_q`−1.
  - After the `cnt_q`=0 word, the state moves to TURN.
- **TURN**
  - One cycle with `wren`=`cpen`=0 and the bus high-Z.
  - Next state is always IDLE; back-to-back bursts are therefore separated by ≥1 idle bus cycle.
- **Address arithmetic:** modulo 2^ADDRESS_WIDTH; 0xFFFF+1 wraps to 0x0000 with no error.
- **Request capture:** a request is captured only in IDLE. `req_*` changes outside IDLE are ignored.
- **Reset mid-burst:** the burst aborts with no further `rsp_valid`. The next state is IDLE.
- **Reset values (all outputs):**
  - `req_ready`=1.
  - `wdata_ready`, `rsp_valid`, `rsp_last`, `wren`, `cpen`, `busy` = 0.
  - `address`=0 and `rsp_rdata`=0.
  - `data` is high-Z.

## Timing
- All bus outputs come from registers; there is no combinational path from `req_*` or `wdata*` to the bus.
- **Request:** handshake at edge E0; `busy`=1 and the WR/RD bus activity starts at E1.
- **Write throughput:** 1 word/cycle with `wdata_valid` held high. An N-word write occupies N bus cycles plus 1 TURN cycle.
- **Read throughput:** READ_LATENCY+1 cycles per word. `rsp_valid` follows the sample edge by 1 cycle.
- **TURN to IDLE:** `req_ready` returns 1 in the cycle after TURN.
- **Drive rule:** `data` is driven only during cycles with `wren`=1. The read phase never drives it.

## Test plan
- **Reset state:** hold `rst_n`=0 for 2 cycles, then release → `req_ready`=1, `wren`=`cpen`=0, `data`=Z, `address`=0.
- **Basic write:** write burst at addr 0x0000, len 1, words 0x4000 then 0x01C0 → bus shows (0x0000, 0x4000, wren=1) then (0x0001, 0x01C0, wren=1), then one TURN cycle, then IDLE.
- **Read-back:** read burst at 0x0000, len 1, with a core model returning the stored words → `rsp_rdata`=0x4000, then 0x01C0 with `rsp_last`=1; `data` is never driven by the master.
- **Wrap and stall:** write burst at 0xFFFF, len 1, with `wdata_valid` deasserted for 2 cycles between words → addresses are 0xFFFF then 0x0000; `wren`=0 during the stall; still exactly 2 writes.
- **Reset mid-burst:** read burst len 3, assert `rst_n`=0 after the second `rsp_valid` → no further `rsp_valid`; all outputs at reset values in the cycle after the reset edge.
- **Back-to-back bursts:** `req_valid` held high with a write burst then a read burst → ≥1 cycle with `cpen`=0 between `wren`=1 and the first read address cycle.

Source files
------------

// File: rtl/core_bus_master.sv
// Host-side burst initiator for the core's shared memory port.
// Accepts read/write burst requests, streams write words onto the bus and returns read words.
// It also owns bus turnaround, so the shared data bus is never driven from both ends.
module core_bus_master #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,

  // Burst request channel
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,

  // Write word stream
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [DATA_WIDTH-1:0]    wdata,

  // Read response stream (no backpressure)
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_last,

  // Core memory port
  output logic [ADDRESS_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0]    data,
  output logic                     wren,
  output logic                     cpen,

  output logic                     busy
);

  // The latency counter must be able to hold READ_LATENCY itself.
  localparam int unsigned LatW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [LatW-1:0] LatMax = LatW'(READ_LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StTurn
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]     cnt_q;
  logic [LatW-1:0]          lat_q;
  logic [DATA_WIDTH-1:0]    data_q;

  // Handshake and status flags are decodes of the state register only.
  always_comb begin
    req_ready   = (state_q == StIdle);
    wdata_ready = (state_q == StWr);
    busy        = (state_q != StIdle);
  end

  // The bus is driven only during a registered write cycle; every other cycle leaves it high-Z.
  assign data = (wren && cpen) ? data_q : {DATA_WIDTH{1'bz}};

  // Burst FSM: all bus and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      data_q    <= '0;
      address   <= '0;
      wren      <= 1'b0;
      cpen      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // Response strobes are single-cycle pulses; rsp_rdata holds its value.
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          wren <= 1'b0;
          cpen <= 1'b0;
          if (req_valid) begin
            addr_q  <= req_addr;
            cnt_q   <= req_len;
            lat_q   <= '0;
            state_q <= req_write ? StWr : StRd;
          end
        end

        StWr: begin
          if (wdata_valid) begin
            // One accepted word becomes exactly one bus write cycle.
            address <= addr_q;
            data_q  <= wdata;
            wren    <= 1'b1;
            cpen    <= 1'b1;
            addr_q  <= addr_q + 1'b1;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= StTurn;
            end
          end else begin
            // Stall: release the bus until the next word arrives.
            wren <= 1'b0;
            cpen <= 1'b0;
          end
        end

        StRd: begin
          address <= addr_q;
          wren    <= 1'b0;
          cpen    <= 1'b1;
          if (lat_q == LatMax) begin
            // Sample edge: the address has been stable for READ_LATENCY cycles.
            rsp_rdata <= data;
            rsp_valid <= 1'b1;
            rsp_last  <= (cnt_q == '0);
            addr_q    <= addr_q + 1'b1;
            cnt_q     <= cnt_q - 1'b1;
            lat_q     <= '0;
            if (cnt_q == '0) begin
              // Drop the port enable now so the turnaround cycle is bus-idle.
              cpen    <= 1'b0;
              state_q <= StTurn;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end

        StTurn: begin
          wren    <= 1'b0;
          cpen    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          wren    <= 1'b0;
          cpen    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_master.sv
// Self-checking bench for core_bus_master: a behavioural core memory on the bus,
// a reference memory image kept from the requested bursts, and per-scenario checks.
module tb_core_bus_master;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned RL = 1;
  // Value the bench's bus keeper drives whenever neither side should be driving.
  localparam logic [DW-1:0] Keep = 16'hA5C3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wdata_valid = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          req_ready, wdata_ready, rsp_valid, rsp_last, wren, cpen, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  wire  [DW-1:0] data;

  bit   [DW-1:0] core_mem [65536];
  bit   [DW-1:0] ref_mem  [65536];
  logic [DW-1:0] wbuf     [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  int            wr_cyc[$];
  logic [DW-1:0] rs_d[$];
  logic          rs_l[$];
  int            rs_cyc[$];
  int            rd_cyc[$];

  core_bus_master #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .LEN_WIDTH    (LW),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_last   (rsp_last),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .cpen       (cpen),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Core side: returns stored words while enabled for reads, otherwise a keeper value.
  assign data = wren ? {DW{1'bz}} : (cpen ? core_mem[address] : Keep);

  // Bus monitor: logs the cycle that is ending and commits core writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wren && cpen) begin
      core_mem[address] <= data;
      wr_a.push_back(address);
      wr_d.push_back(data);
      wr_cyc.push_back(cyc);
    end
    if (cpen && !wren) rd_cyc.push_back(cyc);
    if (rsp_valid) begin
      rs_d.push_back(rsp_rdata);
      rs_l.push_back(rsp_last);
      rs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_cyc.delete();
    rs_d.delete(); rs_l.delete(); rs_cyc.delete(); rd_cyc.delete();
  endtask

  // Present a request at a negedge; returns at the negedge after the handshake edge.
  task automatic issue_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input bit keep, output bit ok, output int hc);
    int g = 0;
    req_write = wr; req_addr = a; req_len = len; req_valid = 1'b1;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    ok = req_ready;
    @(posedge clk);
    @(negedge clk);
    hc = cyc;
    if (!keep) req_valid = 1'b0;
  endtask

  // Stream wbuf[0..n-1]; optional fixed stall before word stall_at, or random gaps.
  task automatic feed_words(input int n, input int stall_at, input int stall_len, input bit rnd);
    int i = 0, g = 0, st = 0;
    bit acc;
    while (i < n && g < 400) begin
      if ((i == stall_at && st < stall_len) || (rnd && $urandom_range(0, 3) == 0)) begin
        wdata_valid = 1'b0;
        if (i == stall_at) st++;
      end else begin
        wdata_valid = 1'b1;
        wdata = wbuf[i];
      end
      acc = wdata_valid && wdata_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      g++;
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int g = 0;
    while (!req_ready && g < 40) begin @(negedge clk); g++; end
    ok = req_ready;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int g = 0;
    while (rs_d.size() < n && g < 400) begin @(negedge clk); g++; end
    ok = (rs_d.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({req_ready, wdata_ready, rsp_valid, rsp_last, wren, cpen, busy} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 1000000",
               {req_ready, wdata_ready, rsp_valid, rsp_last, wren, cpen, busy});
    end
    checks++;
    if (address !== 16'h0000) begin
      failures++; $display("FAIL reset_address: got %h want 0000", address);
    end
    checks++;
    if (rsp_rdata !== 16'h0000) begin
      failures++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata);
    end
    checks++;
    if (data !== Keep) begin
      failures++; $display("FAIL reset_data_released: got %h want %h", data, Keep);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle: ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_basic_write();
    bit ok; int hc;
    clear_logs();
    wbuf[0] = 16'h4000; wbuf[1] = 16'h01C0;
    issue_req(1'b1, 16'h0000, 8'd1, 1'b0, ok, hc);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_req: req_ready=0 want 1"); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
    feed_words(2, -1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if ({wren, cpen} !== 2'b00 || data !== Keep) begin
      failures++;
      $display("FAIL basic_turn: wren=%b cpen=%b data=%h want 0 0 %h", wren, cpen, data, Keep);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_idle: req_ready=0 want 1"); end
    checks++;
    if (wr_a.size() != 2) begin
      failures++; $display("FAIL basic_count: got %0d writes want 2", wr_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_a[i] !== AW'(i) || wr_d[i] !== wbuf[i]) begin
          failures++;
          $display("FAIL basic_word%0d: got (%h,%h) want (%h,%h)", i, wr_a[i], wr_d[i],
                   AW'(i), wbuf[i]);
        end
      end
      checks++;
      if (wr_cyc[0] != hc + 1 || wr_cyc[1] != hc + 2) begin
        failures++;
        $display("FAIL basic_timing: write cycles %0d,%0d want %0d,%0d", wr_cyc[0] - hc,
                 wr_cyc[1] - hc, 1, 2);
      end
    end
    ref_mem[0] = 16'h4000; ref_mem[1] = 16'h01C0;
  endtask

  task automatic test_read_back();
    bit ok; int hc;
    clear_logs();
    issue_req(1'b0, 16'h0000, 8'd1, 1'b0, ok, hc);
    wait_rsp(2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rdback_timeout: got %0d rsp want 2", rs_d.size()); end
    wait_idle(ok);
    checks++;
    if (rs_d.size() != 2) begin
      failures++; $display("FAIL rdback_count: got %0d want 2", rs_d.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rs_d[i] !== ref_mem[i] || rs_l[i] !== (i == 1)) begin
          failures++;
          $display("FAIL rdback_word%0d: got (%h,last=%b) want (%h,last=%b)", i, rs_d[i],
                   rs_l[i], ref_mem[i], (i == 1));
        end
      end
      checks++;
      if (rs_cyc[0] != hc + int'(RL) + 1 || rs_cyc[1] - rs_cyc[0] != int'(RL) + 1) begin
        failures++;
        $display("FAIL rdback_timing: first %0d spacing %0d want %0d %0d", rs_cyc[0] - hc,
                 rs_cyc[1] - rs_cyc[0], RL + 1, RL + 1);
      end
    end
    checks++;
    if (wr_a.size() != 0) begin
      failures++; $display("FAIL rdback_no_drive: got %0d write cycles want 0", wr_a.size());
    end
  endtask

  task automatic test_wrap_stall();
    bit ok; int hc;
    clear_logs();
    wbuf[0] = DW'($urandom); wbuf[1] = DW'($urandom);
    issue_req(1'b1, 16'hFFFF, 8'd1, 1'b0, ok, hc);
    feed_words(2, 1, 2, 1'b0);
    wait_idle(ok);
    checks++;
    if (wr_a.size() != 2) begin
      failures++; $display("FAIL wrap_count: got %0d writes want 2", wr_a.size());
    end else begin
      checks++;
      if (wr_a[0] !== 16'hFFFF || wr_a[1] !== 16'h0000) begin
        failures++; $display("FAIL wrap_addr: got %h,%h want FFFF,0000", wr_a[0], wr_a[1]);
      end
      checks++;
      if (wr_d[0] !== wbuf[0] || wr_d[1] !== wbuf[1]) begin
        failures++;
        $display("FAIL wrap_data: got %h,%h want %h,%h", wr_d[0], wr_d[1], wbuf[0], wbuf[1]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 3) begin
        failures++; $display("FAIL wrap_stall_gap: got %0d want 3", wr_cyc[1] - wr_cyc[0]);
      end
    end
    ref_mem[16'hFFFF] = wbuf[0]; ref_mem[16'h0000] = wbuf[1];
  endtask

  task automatic test_random();
    bit ok; int hc; int n; logic [AW-1:0] a;
    for (int it = 0; it < 6; it++) begin
      a = (it == 0) ? 16'hFFFC : AW'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wbuf[i] = DW'($urandom);
      clear_logs();
      issue_req(1'b1, a, LW'(n - 1), 1'b0, ok, hc);
      feed_words(n, -1, 0, 1'b1);
      wait_idle(ok);
      for (int i = 0; i < n; i++) ref_mem[AW'(a + AW'(i))] = wbuf[i];
      checks++;
      if (wr_a.size() != n) begin
        failures++; $display("FAIL rand_wr_count%0d: got %0d want %0d", it, wr_a.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wr_a[i] !== AW'(a + AW'(i)) || wr_d[i] !== wbuf[i]) begin
            failures++;
            $display("FAIL rand_wr%0d_%0d: got (%h,%h) want (%h,%h)", it, i, wr_a[i], wr_d[i],
                     AW'(a + AW'(i)), wbuf[i]);
          end
        end
      end
      clear_logs();
      issue_req(1'b0, a, LW'(n - 1), 1'b0, ok, hc);
      wait_rsp(n, ok);
      wait_idle(ok);
      checks++;
      if (rs_d.size() != n) begin
        failures++; $display("FAIL rand_rd_count%0d: got %0d want %0d", it, rs_d.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (rs_d[i] !== ref_mem[AW'(a + AW'(i))] || rs_l[i] !== (i == n - 1)) begin
            failures++;
            $display("FAIL rand_rd%0d_%0d: got (%h,last=%b) want (%h,last=%b)", it, i, rs_d[i],
                     rs_l[i], ref_mem[AW'(a + AW'(i))], (i == n - 1));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int hc; int cnt = 0; int g = 0; int extra = 0;
    logic [DW-1:0] last_d = '0;
    logic [AW-1:0] a = AW'($urandom);
    clear_logs();
    issue_req(1'b0, a, 8'd3, 1'b0, ok, hc);
    while (cnt < 2 && g < 100) begin
      @(negedge clk); g++;
      if (rsp_valid) begin cnt++; last_d = rsp_rdata; end
    end
    checks++;
    if (cnt != 2 || last_d !== ref_mem[AW'(a + 1'b1)]) begin
      failures++;
      $display("FAIL midrst_pre: pulses %0d data %h want 2 %h", cnt, last_d, ref_mem[AW'(a + 1'b1)]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, wdata_ready, rsp_valid, rsp_last, wren, cpen, busy} !== 7'b1000000 ||
        address !== 16'h0000 || rsp_rdata !== 16'h0000 || data !== Keep) begin
      failures++;
      $display("FAIL midrst_values: flags %b addr %h rdata %h data %h want 1000000 0000 0000 %h",
               {req_ready, wdata_ready, rsp_valid, rsp_last, wren, cpen, busy}, address,
               rsp_rdata, data, Keep);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", extra); end
  endtask

  task automatic test_back_to_back();
    bit ok; int hc; int g = 0;
    logic [AW-1:0] a = AW'($urandom);
    for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom);
    clear_logs();
    issue_req(1'b1, a, 8'd2, 1'b1, ok, hc);
    // Next request queued while the write is running; it must not disturb the write.
    req_write = 1'b0; req_addr = a; req_len = 8'd2;
    feed_words(3, -1, 0, 1'b0);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[AW'(a + AW'(i))] = wbuf[i];
    wait_rsp(3, ok);
    wait_idle(ok);
    checks++;
    if (wr_a.size() != 3 || rs_d.size() != 3 || rd_cyc.size() == 0) begin
      failures++;
      $display("FAIL b2b_count: writes %0d reads %0d want 3 3", wr_a.size(), rs_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_a[i] !== AW'(a + AW'(i)) || wr_d[i] !== wbuf[i] ||
            rs_d[i] !== ref_mem[AW'(a + AW'(i))]) begin
          failures++;
          $display("FAIL b2b_word%0d: wr (%h,%h) rd %h want (%h,%h) %h", i, wr_a[i], wr_d[i],
                   rs_d[i], AW'(a + AW'(i)), wbuf[i], ref_mem[AW'(a + AW'(i))]);
        end
      end
      checks++;
      if (rd_cyc[0] - wr_cyc[2] < 2) begin
        failures++;
        $display("FAIL b2b_gap: got %0d cycles want >=2", rd_cyc[0] - wr_cyc[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_read_back();
    test_wrap_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
